mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative multiply/divide unit in the execute stage, beside the ALU. It takes the same
//  SrcA/SrcB operands and holds the MIPS HI/LO registers. HI/LO feed the writeback mux
//  (MFHI/MFLO). The CPU control stalls the PC while Busy is high.
//  Covers MULT, MULTU, DIV, DIVU, MTHI and MTLO.
// PARAMETERS
//  WIDTH   32   operand and HI/LO width; the iteration count equals WIDTH
// PORTS
//  clk      in   1      rising-edge clock (one clock domain)
//  rst      in   1      synchronous, active-high reset
//  SrcA     in   32     operand A: multiplicand, dividend, or MTHI/MTLO data
//  SrcB     in   32     operand B: multiplier or divisor
//  MD_Opt   in   3      operation code (values in the package)
//  Start    in   1      request; sampled only when Busy=0
//  Busy     out  1      operation in flight; the CPU stalls while this is high
//  Done     out  1      one-cycle pulse when HI/LO take a mult/div result
//  HI       out  32     HI register (remainder, or upper product)
//  LO       out  32     LO register (quotient, or lower product)
// BEHAVIOUR
//  Reset: Busy=0, Done=0, HI=0, LO=0, FSM=IDLE, counter=0.
//  Reset during an operation aborts it. No Done pulse. HI/LO are 0 after the reset edge.
//  FSM states:
//  - IDLE: on edge E0 with Start=1 and op in {MULT,MULTU,DIV,DIVU}, latch operands
//    (magnitudes for signed ops) and result signs. Go to CALC. Busy=1 after E0.
//  - CALC: one radix-2 step per edge on E1..E32; counter counts 0..WIDTH-1.
//  - FIX: edge E33 applies sign correction and writes HI/LO. Busy goes to 0 and Done to 1
//    on the same edge. Next edge goes to IDLE and Done returns to 0.
//  Latency: results are visible after E33 (33 edges after the accepting edge).
//  - Back-to-back: a new Start can be accepted at E34.
//  MTHI / MTLO:
//  - With Busy=0 and Start=1: HI (or LO) <= SrcA at the next edge.
//  - Busy stays 0 and Done is not pulsed.
//  Requests ignored (state and HI/LO unchanged):
//  - Start while Busy=1, for any MD_Opt.
//  - Undefined MD_Opt codes.
//  Multiply: HI:LO = full 64-bit product.
//  - MULT is two's-complement signed. MULTU is unsigned.
//  - Shift-add on magnitudes, then the 64-bit product is negated if the signs differ.
//  Divide: restoring divide on magnitudes.
//  - Signed quotient truncates toward zero. The remainder takes the dividend's sign.
//  - Divisor 0: HI=SrcA, LO=32'hFFFF_FFFF, with the same 33-edge latency.
//  - DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0 (no trap).
//  Operands are captured at E0. SrcA/SrcB/MD_Opt changing during CALC has no effect.
// STRUCTURE
//  Shared package md_pkg: MD_Opt encodings, FSM state encodings, and the CNT_W constant.
//  - MD_NOP=3'b000, MD_MULT=3'b001, MD_MULTU=3'b010, MD_DIV=3'b011, MD_DIVU=3'b100,
//    MD_MTHI=3'b101, MD_MTLO=3'b110 (3'b111 undefined).
//  - FSM states: IDLE, CALC, FIX.
//  - CNT_W = $clog2(WIDTH)+1.
//  Sub-module md_step: combinational single iteration, shared by both ops.
//  - Multiply: conditional add plus shift.
//  - Divide: trial subtract plus shift.
//  Top level holds the FSM, counter, operand/accumulator registers and HI/LO.
// TESTING
//  1 MULTU FFFFFFFF x FFFFFFFF -> HI=FFFFFFFE, LO=00000001.
//    Busy high for exactly 33 edges after E0; Done pulses for exactly 1 cycle.
//  2 MULT -3 x 7 -> HI=FFFFFFFF, LO=FFFFFFEB. MULT 0 x 80000000 -> HI=LO=0.
//  3 DIVU 100 / 7 -> LO=0000000E, HI=00000002.
//    DIV -7 / 2 -> LO=FFFFFFFD, HI=FFFFFFFF.
//  4 DIV 12345678 / 0 -> HI=12345678, LO=FFFFFFFF.
//    DIV 80000000 / FFFFFFFF -> LO=80000000, HI=0.
//  5 MTHI DEADBEEF, then MTLO CAFEF00D -> HI/LO update 1 edge after each request.
//    Busy stays 0 and Done stays 0 throughout.
//  6 Start MTHI at CALC edge 5 -> ignored; the final result matches case 1.
//    rst at CALC edge 10 -> Busy=0, HI=LO=0 after that edge, no Done pulse.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the iterative multiply/divide unit.
//   - MD_WIDTH : default operand / HI / LO width
//   - CNT_W    : iteration counter width
//   - md_op_e  : MD_Opt operation encodings
//   - md_state_e : sequencer states
package md_pkg;

    localparam int MD_WIDTH = 32;
    localparam int CNT_W    = $clog2(MD_WIDTH) + 1;

    typedef enum logic [2:0] {
        MD_NOP   = 3'b000,
        MD_MULT  = 3'b001,
        MD_MULTU = 3'b010,
        MD_DIV   = 3'b011,
        MD_DIVU  = 3'b100,
        MD_MTHI  = 3'b101,
        MD_MTLO  = 3'b110
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle between the CPU execute stage and
// the multiply/divide unit.
//   master (CPU)  : drives SrcA, SrcB, MD_Opt, Start; observes Busy, Done, HI, LO
//   slave  (unit) : the reverse
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [2:0]       MD_Opt;
    logic             Start;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output SrcA, SrcB, MD_Opt, Start,
        input  Busy, Done, HI, LO
    );

    modport slave (
        input  SrcA, SrcB, MD_Opt, Start,
        output Busy, Done, HI, LO
    );
endinterface

// File: rtl/md_step.sv
// md_step: one combinational radix-2 iteration on unsigned magnitudes.
//   is_div   : 1 = restoring-divide step, 0 = shift-add multiply step
//   hi, lo   : current accumulator (product high/low, or remainder/quotient)
//   opnd     : multiplicand or divisor magnitude
//   hi_next, lo_next : accumulator after this iteration
module md_step
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   r_shift;
    logic             fits;
    logic [WIDTH-1:0] diff;

    always_comb begin
        // multiply: lo holds the remaining multiplier bits, LSB first;
        // the carry out of the add is shifted straight back into hi
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        // divide: bring the next dividend bit (lo MSB) into the remainder
        r_shift = {hi, lo[WIDTH-1]};
        fits    = (r_shift >= {1'b0, opnd});
        // when fits, the true difference is below opnd, so WIDTH bits suffice
        diff    = r_shift[WIDTH-1:0] - opnd;

        if (is_div) begin
            hi_next = fits ? diff : r_shift[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], fits};
        end else begin
            hi_next = sum[WIDTH:1];
            lo_next = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO
// registers, plus MTHI/MTLO writes.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (aborts any operation in flight)
//   bus  : slave side of mult_div_unit_if (operands, MD_Opt, Start in;
//          Busy, Done, HI, LO out)
// A mult/div accepted on edge E0 iterates on E1..E32 and writes HI/LO on
// E33 with a one-cycle Done pulse; Busy covers E0..E33.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic clk,
    input  logic rst,
    mult_div_unit_if.slave bus
);

    md_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd_b;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic             busy_r, done_r;
    logic             is_div, neg_lo, neg_hi, div_zero;

    logic [WIDTH-1:0]   step_hi, step_lo;
    logic               signed_op, sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    md_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .hi      (acc_hi),
        .lo      (acc_lo),
        .opnd    (opnd_b),
        .hi_next (step_hi),
        .lo_next (step_lo)
    );

    always_comb begin
        signed_op = (bus.MD_Opt == MD_MULT) || (bus.MD_Opt == MD_DIV);
        sign_a    = signed_op & bus.SrcA[WIDTH-1];
        sign_b    = signed_op & bus.SrcB[WIDTH-1];
        mag_a     = sign_a ? -bus.SrcA : bus.SrcA;
        mag_b     = sign_b ? -bus.SrcB : bus.SrcB;

        prod      = {acc_hi, acc_lo};
        prod_fix  = neg_lo ? -prod : prod;
        // a zero divisor leaves the dividend in the remainder; only the
        // quotient needs forcing to all ones
        quo_fix   = div_zero ? '1 : (neg_lo ? -acc_lo : acc_lo);
        rem_fix   = neg_hi ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd_b   <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.Start) begin
                        case (md_op_e'(bus.MD_Opt))
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                acc_hi   <= '0;
                                acc_lo   <= mag_a;
                                opnd_b   <= mag_b;
                                is_div   <= (bus.MD_Opt == MD_DIV) || (bus.MD_Opt == MD_DIVU);
                                neg_lo   <= sign_a ^ sign_b;
                                neg_hi   <= sign_a;
                                div_zero <= (bus.SrcB == '0);
                                cnt      <= '0;
                                busy_r   <= 1'b1;
                                state    <= CALC;
                            end
                            MD_MTHI: hi_r <= bus.SrcA;
                            MD_MTLO: lo_r <= bus.SrcA;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        hi_r <= rem_fix;
                        lo_r <= quo_fix;
                    end else begin
                        {hi_r, lo_r} <= prod_fix;
                    end
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Busy = busy_r;
    assign bus.Done = done_r;
    assign bus.HI   = hi_r;
    assign bus.LO   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed bench for mult_div_unit with an arithmetic
// reference model compared every cycle, plus literal result checks.
module tb_mult_div_unit;
    import md_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // reference model state: results appear 33 edges after acceptance
    logic        m_busy, m_done;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    int          m_left = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, uq, ur, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        case (op)
            MD_MULT:  r = sa * sb;
            MD_MULTU: r = ua * ub;
            MD_DIV: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {sr[31:0], sq[31:0]};
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    r  = {ur[31:0], uq[31:0]};
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end else if (bus.Start) begin
                case (bus.MD_Opt)
                    MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                        m_res  <= model_result(bus.MD_Opt, bus.SrcA, bus.SrcB);
                        m_left <= 33;
                        m_busy <= 1'b1;
                    end
                    MD_MTHI: m_hi <= bus.SrcA;
                    MD_MTLO: m_lo <= bus.SrcA;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_busy", {63'd0, bus.Busy}, {63'd0, m_busy});
            chk("model_done", {63'd0, bus.Done}, {63'd0, m_done});
            chk("model_hi", {32'd0, bus.HI}, {32'd0, m_hi});
            chk("model_lo", {32'd0, bus.LO}, {32'd0, m_lo});
        end
    end

    // called at a negedge; the request is sampled on the next rising edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start  = 1'b1;
        bus.MD_Opt = op;
        bus.SrcA   = a;
        bus.SrcB   = b;
        @(negedge clk);
        bus.Start  = 1'b0;
        bus.MD_Opt = MD_NOP;
        bus.SrcA   = $urandom;
        bus.SrcB   = $urandom;
    endtask

    task automatic wait_done(output int busy_cyc, output logic found);
        busy_cyc = 0;
        found    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.Done) begin
                found = 1'b1;
                break;
            end
            if (bus.Busy) busy_cyc++;
            @(negedge clk);
        end
    endtask

    vec_t vecs[8];

    initial begin
        int   bc;
        int   dcount;
        logic found;

        vecs[0] = '{MD_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{MD_MULT,  32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[2] = '{MD_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
        vecs[3] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{MD_DIV,   32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
        vecs[5] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[6] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[7] = '{MD_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};

        rst        = 1'b1;
        bus.Start  = 1'b0;
        bus.MD_Opt = MD_NOP;
        bus.SrcA   = '0;
        bus.SrcB   = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {63'd0, bus.Busy}, 64'd0);
        chk("reset_done", {63'd0, bus.Done}, 64'd0);
        chk("reset_hi", {32'd0, bus.HI}, 64'd0);
        chk("reset_lo", {32'd0, bus.LO}, 64'd0);
        rst    = 1'b0;
        cmp_en = 1'b1;

        // MULTU max x max, with latency and pulse width
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(bc, found);
        chk("c1_done_seen", {63'd0, found}, 64'd1);
        chk("c1_busy_cycles", 64'(bc), 64'd33);
        chk("c1_hi", {32'd0, bus.HI}, 64'h0000_0000_FFFF_FFFE);
        chk("c1_lo", {32'd0, bus.LO}, 64'h0000_0000_0000_0001);
        @(negedge clk);
        chk("c1_done_width", {63'd0, bus.Done}, 64'd0);

        // directed vectors, issued back-to-back straight after each Done
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(bc, found);
            chk($sformatf("vec%0d_done_seen", i), {63'd0, found}, 64'd1);
            chk($sformatf("vec%0d_hi", i), {32'd0, bus.HI}, {32'd0, vecs[i].hi});
            chk($sformatf("vec%0d_lo", i), {32'd0, bus.LO}, {32'd0, vecs[i].lo});
        end

        // MTHI / MTLO, then ignored codes
        issue(MD_MTHI, 32'hDEAD_BEEF, 32'd0);
        chk("mthi_hi", {32'd0, bus.HI}, 64'h0000_0000_DEAD_BEEF);
        chk("mthi_busy", {63'd0, bus.Busy}, 64'd0);
        chk("mthi_done", {63'd0, bus.Done}, 64'd0);
        issue(MD_MTLO, 32'hCAFE_F00D, 32'd0);
        chk("mtlo_lo", {32'd0, bus.LO}, 64'h0000_0000_CAFE_F00D);
        chk("mtlo_hi_kept", {32'd0, bus.HI}, 64'h0000_0000_DEAD_BEEF);
        chk("mtlo_busy", {63'd0, bus.Busy}, 64'd0);
        chk("mtlo_done", {63'd0, bus.Done}, 64'd0);
        issue(3'b111, 32'h1111_1111, 32'h2222_2222);
        issue(MD_NOP, 32'h3333_3333, 32'h4444_4444);
        @(negedge clk);
        chk("undef_hi", {32'd0, bus.HI}, 64'h0000_0000_DEAD_BEEF);
        chk("undef_lo", {32'd0, bus.LO}, 64'h0000_0000_CAFE_F00D);
        chk("undef_busy", {63'd0, bus.Busy}, 64'd0);

        // MTHI request during CALC edge 5 must be ignored
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        bus.Start  = 1'b1;
        bus.MD_Opt = MD_MTHI;
        bus.SrcA   = 32'h1111_1111;
        @(negedge clk);
        bus.Start  = 1'b0;
        bus.MD_Opt = MD_NOP;
        wait_done(bc, found);
        chk("c6_done_seen", {63'd0, found}, 64'd1);
        chk("c6_hi", {32'd0, bus.HI}, 64'h0000_0000_FFFF_FFFE);
        chk("c6_lo", {32'd0, bus.LO}, 64'h0000_0000_0000_0001);
        @(negedge clk);

        // reset at CALC edge 10 aborts without a Done pulse
        issue(MD_DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {63'd0, bus.Busy}, 64'd0);
        chk("abort_done", {63'd0, bus.Done}, 64'd0);
        chk("abort_hi", {32'd0, bus.HI}, 64'd0);
        chk("abort_lo", {32'd0, bus.LO}, 64'd0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.Done) dcount++;
        end
        chk("abort_no_done", 64'(dcount), 64'd0);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
